icon_draw_engine: RTL
=====================

# icon_draw_engine

Pixel-drawing stage between the home-simulation datapath and the VGA adapter. It takes the room icon origin (x/y coordinates), icon type (light/door) and ON/OFF state and sweeps an ICON_W×ICON_H bitmap onto the screen, one pixel per clock. It also wipes the full screen on a clear request. When either sweep finishes it returns the single-cycle `count_done` that the control path waits on in its ROOMn and CLEAR states.

## Interface
Parameters:
- ICON_W, 8, icon width in pixels (power of two)
- ICON_H, 8, icon height in pixels (power of two)
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- BG_COLOUR, 3'b000, background/clear colour

Ports:
- clock  in  1  system clock (CLOCK_50); single clock domain
- reset  in  1  synchronous, active-high
- draw_start  in  1  request icon draw; sampled only in IDLE
- clear_start  in  1  request full-screen clear; sampled only in IDLE
- x_origin  in  8  icon top-left column
- y_origin  in  7  icon top-left row
- icon_sel  in  1  1 = light icon, 0 = door icon (matches keyboard L/D encoding)
- onoff  in  1  1 = ON, 0 = OFF (matches audio encoding)
- x_out  out  8  pixel column to VGA adapter
- y_out  out  7  pixel row to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  write-enable to VGA adapter
- busy  out  1  high in DRAW, CLEAR, DONE
- count_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, CLEAR, DONE.
- IDLE:
  - clear_start=1 → CLEAR. Clear wins if draw_start is also 1.
  - Otherwise draw_start=1 → DRAW.
  - On the transition edge, latch x_origin, y_origin, icon_sel and onoff. Zero the col/row counters.
- DRAW:
  - col counter increments every cycle. On wrap (ICON_W−1→0), row increments.
  - After pixel (ICON_W−1, ICON_H−1) → DONE.
- CLEAR: same sweep over SCREEN_W×SCREEN_H starting at (0,0); then → DONE.
- DONE: count_done=1 for one cycle; → IDLE unconditionally.
- Requests arriving outside IDLE are ignored, not queued. They are not held by this block.
- Pixel address in DRAW:
  - x_out = x_origin+col and y_out = y_origin+row, computed at 9/8 bits and truncated to the port width.
  - If the 9-bit x sum ≥ SCREEN_W or the 8-bit y sum ≥ SCREEN_H, plot=0 for that cycle (clipping). The sweep still takes the full ICON_W×ICON_H cycles.
- Pixel colour in DRAW:
  - Bitmap bit =1: colour = onoff ? 3'b110 (yellow) : 3'b001 (blue) for a light icon; onoff ? 3'b010 (green) : 3'b100 (red) for a door icon.
  - Bitmap bit =0: colour = BG_COLOUR, plot=1 (opaque).
- CLEAR: colour=BG_COLOUR, plot=1 every cycle; x_out/y_out are the counters.
- Reset values: state IDLE, counters 0, latches 0, x_out=0, y_out=0, colour=BG_COLOUR, plot=0, busy=0, count_done=0.

## Timing
- Outputs are combinational decode of registered state/counters/latches. Pixel k of the sweep is presented in the k-th cycle after the start-sampling edge.
- Request sampled at edge N:
  - plot window spans edges N..N+ICON_W·ICON_H (64 cycles by default).
  - count_done is high from edge N+64 to N+65.
  - Next request is accepted at edge N+65 or later.
- Clear: count_done follows edge N+19200.
- Reset during DRAW/CLEAR aborts the sweep: IDLE on the next edge, no count_done. Remaining pixels are left as drawn.
- plot, busy and count_done are never high in IDLE.

## Configuration
- DRAW_TRANSPARENT_EN:
  - Defined: bitmap-0 pixels in DRAW drive plot=0 (transparent); only set bits are written. Sweep length is unchanged.
  - Undefined: opaque behaviour as above.
  - CLEAR is unaffected either way.

## Structure
- Package home_sim_pkg holds:
  - state enum
  - colour constants (COL_YELLOW, COL_BLUE, COL_GREEN, COL_RED, COL_BG)
  - SCREEN_W/SCREEN_H defaults
  - ICON_LIGHT/ICON_DOOR select encodings
- Sub-module icon_rom: combinational bitmap lookup.
  - Inputs: icon_sel, row[log2 ICON_H], col[log2 ICON_W].
  - Output: 1-bit pixel.
  - Contents are two fixed 8×8 glyphs.

## Test plan
- Reset, then draw_start with (60,73), icon_sel=1, onoff=1 → 64 plot cycles; first pixel (60,73), last (67,80); set pixels colour 3'b110; count_done at the 65th cycle; busy low afterwards.
- Draw at (156,118), door, OFF → sweep lasts 64 cycles; plot high only for x∈156..159, y∈118..119 (8 pixels); count_done still at the 65th cycle.
- draw_start and clear_start high together in IDLE → CLEAR; 19200 plot cycles with colour=BG_COLOUR covering (0,0)..(159,119); count_done once.
- draw_start pulsed during DRAW → ignored; exactly one count_done; no second sweep.
- Reset asserted at pixel 20 of DRAW → plot=0 and state IDLE the next cycle; no count_done; fresh draw_start then works normally.
- With DRAW_TRANSPARENT_EN defined, light/ON draw → plot count equals the number of set bits in the light glyph; all plotted colours are 3'b110.

Source files
------------

// File: rtl/home_sim_pkg.sv
// Shared types and constants for the home-simulation display path:
// FSM states, palette, screen defaults, icon select encodings and glyph bitmaps.
package home_sim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAW  = 2'd1,
      ST_CLEAR = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] COL_YELLOW = 3'b110;
   localparam logic [2:0] COL_BLUE   = 3'b001;
   localparam logic [2:0] COL_GREEN  = 3'b010;
   localparam logic [2:0] COL_RED    = 3'b100;
   localparam logic [2:0] COL_BG     = 3'b000;

   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;

   localparam logic ICON_LIGHT = 1'b1;
   localparam logic ICON_DOOR  = 1'b0;

   // Row 0 is the most significant byte; within a row, bit 7 is column 0.
   localparam logic [63:0] GLYPH_LIGHT = 64'h3C7E_7E7E_3C18_3C18;
   localparam logic [63:0] GLYPH_DOOR  = 64'h7E42_4246_4242_427E;

   function automatic logic [2:0] icon_colour(input logic sel, input logic on);
      if (sel == ICON_LIGHT) begin
         return on ? COL_YELLOW : COL_BLUE;
      end else begin
         return on ? COL_GREEN : COL_RED;
      end
   endfunction

endpackage

// File: rtl/icon_rom.sv
// Combinational 8x8 glyph lookup for the light and door icons.
module icon_rom
   import home_sim_pkg::*;
(
   input  logic       icon_sel,
   input  logic [2:0] row,
   input  logic [2:0] col,
   output logic       pixel
);

   logic [63:0] glyph_s;
   logic [5:0]  idx_s;

   always_comb begin
      glyph_s = (icon_sel == ICON_LIGHT) ? GLYPH_LIGHT : GLYPH_DOOR;
      idx_s   = 6'd63 - {row, 3'b000} - {3'b000, col};
      pixel   = glyph_s[idx_s];
   end

endmodule

// File: rtl/icon_draw_engine.sv
// Sweeps an icon bitmap or a full-screen clear onto the VGA adapter, one pixel per clock.
// Optional build macro DRAW_TRANSPARENT_EN makes unset glyph pixels transparent in DRAW.
module icon_draw_engine
   import home_sim_pkg::*;
#(
   parameter int         ICON_W    = 8,
   parameter int         ICON_H    = 8,
   parameter int         SCREEN_W  = SCREEN_W_DEF,
   parameter int         SCREEN_H  = SCREEN_H_DEF,
   parameter logic [2:0] BG_COLOUR = COL_BG
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       draw_start,
   input  logic       clear_start,
   input  logic [7:0] x_origin,
   input  logic [6:0] y_origin,
   input  logic       icon_sel,
   input  logic       onoff,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       count_done
);

   state_t     state_q, state_d;
   logic [7:0] col_q, col_d;
   logic [6:0] row_q, row_d;
   logic [7:0] x_org_q, x_org_d;
   logic [6:0] y_org_q, y_org_d;
   logic       sel_q, sel_d;
   logic       onoff_q, onoff_d;

   logic       pix_s;
   logic [8:0] x_sum_s;
   logic [7:0] y_sum_s;
   logic       in_screen_s;

   icon_rom u_rom (
      .icon_sel (sel_q),
      .row      (row_q[2:0]),
      .col      (col_q[2:0]),
      .pixel    (pix_s)
   );

   // State, sweep counters and request latches
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         col_q   <= 8'd0;
         row_q   <= 7'd0;
         x_org_q <= 8'd0;
         y_org_q <= 7'd0;
         sel_q   <= 1'b0;
         onoff_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         x_org_q <= x_org_d;
         y_org_q <= y_org_d;
         sel_q   <= sel_d;
         onoff_q <= onoff_d;
      end
   end

   // Next-state and sweep advance
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      x_org_d = x_org_q;
      y_org_d = y_org_q;
      sel_d   = sel_q;
      onoff_d = onoff_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_start || draw_start) begin
               state_d = clear_start ? ST_CLEAR : ST_DRAW;
               col_d   = 8'd0;
               row_d   = 7'd0;
               x_org_d = x_origin;
               y_org_d = y_origin;
               sel_d   = icon_sel;
               onoff_d = onoff;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAW: begin
            if (col_q == 8'(ICON_W - 1)) begin
               col_d = 8'd0;
               if (row_q == 7'(ICON_H - 1)) begin
                  state_d = ST_DONE;
                  row_d   = 7'd0;
               end else begin
                  row_d = row_q + 7'd1;
               end
            end else begin
               col_d = col_q + 8'd1;
            end
         end
         ST_CLEAR: begin
            if (col_q == 8'(SCREEN_W - 1)) begin
               col_d = 8'd0;
               if (row_q == 7'(SCREEN_H - 1)) begin
                  state_d = ST_DONE;
                  row_d   = 7'd0;
               end else begin
                  row_d = row_q + 7'd1;
               end
            end else begin
               col_d = col_q + 8'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pixel address, clipping and colour decode
   always_comb begin
      x_sum_s     = {1'b0, x_org_q} + {1'b0, col_q};
      y_sum_s     = {1'b0, y_org_q} + {1'b0, row_q};
      in_screen_s = (x_sum_s < 9'(SCREEN_W)) && (y_sum_s < 8'(SCREEN_H));
      x_out       = 8'd0;
      y_out       = 7'd0;
      colour      = BG_COLOUR;
      plot        = 1'b0;
      busy        = 1'b0;
      count_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_DRAW: begin
            busy   = 1'b1;
            x_out  = x_sum_s[7:0];
            y_out  = y_sum_s[6:0];
            colour = pix_s ? icon_colour(sel_q, onoff_q) : BG_COLOUR;
`ifdef DRAW_TRANSPARENT_EN
            plot   = in_screen_s & pix_s;
`else
            plot   = in_screen_s;
`endif
         end
         ST_CLEAR: begin
            busy  = 1'b1;
            x_out = col_q;
            y_out = row_q;
            plot  = 1'b1;
         end
         ST_DONE: begin
            busy       = 1'b1;
            count_done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
